// File: rtl/rs_sched_pkg.sv
// rs_sched_pkg: shared sizes, types and broadcast-match helper for the RS issue scheduler
package rs_sched_pkg;
    localparam int RS_SIZ = 16;
    localparam int IDX_W = $clog2(RS_SIZ);
    localparam int ROB_W = 4;
    typedef logic [ROB_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [RS_SIZ-1:0] vec_t;
    typedef struct packed {
        logic en;
        tag_t tag;
    } cdb_t;
    function automatic logic cdb_hit(cdb_t alu, cdb_t lsb, tag_t t);
        return (alu.en && alu.tag == t) || (lsb.en && lsb.tag == t);
    endfunction
endpackage

// File: rtl/rs_sched_if.sv
// rs_sched_if: dispatch, broadcast, wake and issue signals between the scheduler and its neighbours
interface rs_sched_if;
    import rs_sched_pkg::*;
    logic rs_full;
    logic alloc_req;
    logic alloc_rs1_rdy;
    tag_t alloc_rs1_tag;
    logic alloc_rs2_rdy;
    tag_t alloc_rs2_tag;
    idx_t alloc_idx;
    logic alu_cdb_en;
    tag_t alu_cdb_tag;
    logic lsb_cdb_en;
    tag_t lsb_cdb_tag;
    vec_t wake_rs1;
    vec_t wake_rs2;
    logic issue_valid;
    idx_t issue_idx;
    logic issue_ready;
    modport master (
        output alloc_req, alloc_rs1_rdy, alloc_rs1_tag, alloc_rs2_rdy, alloc_rs2_tag,
        output alu_cdb_en, alu_cdb_tag, lsb_cdb_en, lsb_cdb_tag, issue_ready,
        input rs_full, alloc_idx, wake_rs1, wake_rs2, issue_valid, issue_idx
    );
    modport slave (
        input alloc_req, alloc_rs1_rdy, alloc_rs1_tag, alloc_rs2_rdy, alloc_rs2_tag,
        input alu_cdb_en, alu_cdb_tag, lsb_cdb_en, lsb_cdb_tag, issue_ready,
        output rs_full, alloc_idx, wake_rs1, wake_rs2, issue_valid, issue_idx
    );
endinterface

// File: rtl/rs_sched_prio_enc.sv
// rs_sched_prio_enc: binary index of the lowest set request bit, plus an any-set flag
module rs_sched_prio_enc #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
    end
    assign valid = |req;
endmodule

// File: rtl/rs_sched.sv
// rs_sched: slot allocation, operand wakeup and lowest-index issue select for the 16-entry RS
module rs_sched
    import rs_sched_pkg::*;
(
    input logic       clk,
    input logic       rst,
    input logic       rdy,
    input logic       rollback,
    rs_sched_if.slave bus
);
    vec_t busy, r1, r2, alloc_sel, issue_sel, wake1, wake2;
    tag_t t1 [RS_SIZ];
    tag_t t2 [RS_SIZ];
    cdb_t alu, lsb;
    idx_t free_idx, pick_idx;
    logic free_any, pick_any, alloc_fire, issue_fire;

    assign alu = {bus.alu_cdb_en, bus.alu_cdb_tag};
    assign lsb = {bus.lsb_cdb_en, bus.lsb_cdb_tag};

    rs_sched_prio_enc #(.N(RS_SIZ), .W(IDX_W)) u_free (
        .req(~busy), .idx(free_idx), .valid(free_any)
    );
    rs_sched_prio_enc #(.N(RS_SIZ), .W(IDX_W)) u_pick (
        .req(busy & r1 & r2), .idx(pick_idx), .valid(pick_any)
    );

    // Outputs are forced quiet while rst is high so nothing leaks from pre-reset state
    assign bus.rs_full     = !rst && !free_any;
    assign bus.alloc_idx   = rst ? '0 : free_idx;
    assign bus.issue_valid = !rst && rdy && pick_any;
    assign bus.issue_idx   = pick_idx;
    assign bus.wake_rs1    = wake1;
    assign bus.wake_rs2    = wake2;

    assign alloc_fire = !rst && rdy && bus.alloc_req && free_any;
    assign issue_fire = bus.issue_valid && bus.issue_ready;
    assign alloc_sel  = alloc_fire ? vec_t'(1) << free_idx : '0;
    assign issue_sel  = issue_fire ? vec_t'(1) << pick_idx : '0;

    // The slot being allocated is free, so it only wakes through the same-cycle bypass
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < RS_SIZ; i++) begin
            wake1[i] = !rst && rdy && (alloc_sel[i]
                ? !bus.alloc_rs1_rdy && cdb_hit(alu, lsb, bus.alloc_rs1_tag)
                : busy[i] && !r1[i] && cdb_hit(alu, lsb, t1[i]));
            wake2[i] = !rst && rdy && (alloc_sel[i]
                ? !bus.alloc_rs2_rdy && cdb_hit(alu, lsb, bus.alloc_rs2_tag)
                : busy[i] && !r2[i] && cdb_hit(alu, lsb, t2[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (rdy && rollback)) begin
            busy <= '0;
            r1   <= '0;
            r2   <= '0;
        end else if (rdy) begin
            busy <= (busy & ~issue_sel) | alloc_sel;
            r1   <= (r1 & ~alloc_sel) | (alloc_sel & {RS_SIZ{bus.alloc_rs1_rdy}}) | wake1;
            r2   <= (r2 & ~alloc_sel) | (alloc_sel & {RS_SIZ{bus.alloc_rs2_rdy}}) | wake2;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            t1[free_idx] <= bus.alloc_rs1_tag;
            t2[free_idx] <= bus.alloc_rs2_tag;
        end
    end

    alloc_when_full: assert property (@(posedge clk) disable iff (rst)
        !(rdy && bus.alloc_req && bus.rs_full))
        else $warning("rs_sched: alloc_req while rs_full dropped");
endmodule

// File: tb/tb_rs_sched.sv
// tb_rs_sched: directed test-plan steps plus random traffic against a slot-table reference model
module tb_rs_sched;
    import rs_sched_pkg::*;

    logic clk = 1'b0;
    logic rst, rdy, rollback;
    int checks = 0;
    int errors = 0;

    rs_sched_if bus ();
    rs_sched dut (.clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        bit busy;
        bit r1;
        bit r2;
        logic [ROB_W-1:0] t1;
        logic [ROB_W-1:0] t2;
    } ent_t;
    ent_t m [RS_SIZ];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(logic [ROB_W-1:0] t);
        return (bus.alu_cdb_en && t == bus.alu_cdb_tag) || (bus.lsb_cdb_en && t == bus.lsb_cdb_tag);
    endfunction

    task automatic clr();
        rollback = 0;
        bus.alloc_req = 0;
        bus.alloc_rs1_rdy = 0;
        bus.alloc_rs1_tag = '0;
        bus.alloc_rs2_rdy = 0;
        bus.alloc_rs2_tag = '0;
        bus.alu_cdb_en = 0;
        bus.alu_cdb_tag = '0;
        bus.lsb_cdb_en = 0;
        bus.lsb_cdb_tag = '0;
        bus.issue_ready = 0;
    endtask

    // One clock: check outputs mid-cycle against the table, then advance the table
    task automatic cycle();
        int a;
        int p;
        bit iv;
        bit af;
        bit waiting;
        logic [RS_SIZ-1:0] w1;
        logic [RS_SIZ-1:0] w2;
        @(negedge clk);
        a = -1;
        p = -1;
        for (int i = 0; i < RS_SIZ; i++) if (!m[i].busy) begin a = i; break; end
        for (int i = 0; i < RS_SIZ; i++) if (m[i].busy && m[i].r1 && m[i].r2) begin p = i; break; end
        af = !rst && rdy && bus.alloc_req && a >= 0;
        iv = !rst && rdy && p >= 0;
        w1 = '0;
        w2 = '0;
        if (!rst && rdy) begin
            for (int i = 0; i < RS_SIZ; i++) begin
                if (m[i].busy) begin
                    w1[i] = !m[i].r1 && hit(m[i].t1);
                    w2[i] = !m[i].r2 && hit(m[i].t2);
                end
            end
            if (af) begin
                waiting = !bus.alloc_rs1_rdy;
                w1[a] = waiting && hit(bus.alloc_rs1_tag);
                waiting = !bus.alloc_rs2_rdy;
                w2[a] = waiting && hit(bus.alloc_rs2_tag);
            end
        end
        chk("rs_full", 32'(bus.rs_full), 32'(!rst && a < 0));
        chk("alloc_idx", 32'(bus.alloc_idx), (rst || a < 0) ? 0 : a);
        chk("issue_valid", 32'(bus.issue_valid), 32'(iv));
        if (iv) chk("issue_idx", 32'(bus.issue_idx), p);
        chk("wake_rs1", 32'(bus.wake_rs1), 32'(w1));
        chk("wake_rs2", 32'(bus.wake_rs2), 32'(w2));
        if (rst || (rdy && rollback)) begin
            foreach (m[i]) begin
                m[i].busy = 0;
                m[i].r1 = 0;
                m[i].r2 = 0;
            end
        end else if (rdy) begin
            foreach (m[i]) begin
                m[i].r1 = m[i].r1 | w1[i];
                m[i].r2 = m[i].r2 | w2[i];
            end
            if (iv && bus.issue_ready) m[p].busy = 0;
            if (af) m[a] = '{1'b1, bus.alloc_rs1_rdy | w1[a], bus.alloc_rs2_rdy | w2[a],
                             bus.alloc_rs1_tag, bus.alloc_rs2_tag};
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        foreach (m[i]) m[i] = '{1'b0, 1'b0, 1'b0, '0, '0};
        rst = 1;
        rdy = 1;
        clr();
        repeat (2) cycle();
        rst = 0;
        // fill all 16 slots with pending operands, then one alloc too many
        for (int i = 0; i < 17; i++) begin
            clr();
            bus.alloc_req = 1;
            bus.alloc_rs1_tag = 4'(i);
            bus.alloc_rs2_tag = 4'(i + 1);
            cycle();
        end
        clr();
        cycle();
        chk("full_after_16", 32'(bus.rs_full), 32'd1);
        clr();
        rollback = 1;
        cycle();
        clr();
        cycle();
        // wake from ALU two cycles after alloc
        clr();
        bus.alloc_req = 1;
        bus.alloc_rs1_tag = 4'd3;
        bus.alloc_rs2_rdy = 1;
        cycle();
        clr();
        cycle();
        clr();
        bus.alu_cdb_en = 1;
        bus.alu_cdb_tag = 4'd3;
        cycle();
        chk("woken_slot0_valid", 32'(bus.issue_valid), 32'd1);
        clr();
        bus.issue_ready = 1;
        cycle();
        // same-cycle bypass from LSB
        clr();
        bus.alloc_req = 1;
        bus.alloc_rs1_rdy = 1;
        bus.alloc_rs2_tag = 4'd5;
        bus.lsb_cdb_en = 1;
        bus.lsb_cdb_tag = 4'd5;
        cycle();
        clr();
        bus.issue_ready = 1;
        cycle();
        // slots 2 and 7 ready, issue held off then accepted
        for (int i = 0; i < 8; i++) begin
            clr();
            bus.alloc_req = 1;
            bus.alloc_rs1_rdy = (i == 2 || i == 7);
            bus.alloc_rs1_tag = 4'd9;
            bus.alloc_rs2_rdy = 1;
            cycle();
        end
        clr();
        repeat (3) cycle();
        chk("held_idx", 32'(bus.issue_idx), 32'd2);
        clr();
        bus.issue_ready = 1;
        cycle();
        clr();
        cycle();
        chk("next_idx", 32'(bus.issue_idx), 32'd7);
        // grow to 10 busy, then rollback against everything else
        for (int i = 0; i < 3; i++) begin
            clr();
            bus.alloc_req = 1;
            bus.alloc_rs1_tag = 4'd9;
            cycle();
        end
        clr();
        rollback = 1;
        bus.alloc_req = 1;
        bus.alloc_rs1_rdy = 1;
        bus.alloc_rs2_rdy = 1;
        bus.issue_ready = 1;
        bus.alu_cdb_en = 1;
        bus.alu_cdb_tag = 4'd9;
        cycle();
        clr();
        cycle();
        // frozen while a matching broadcast is on the bus
        for (int i = 0; i < 4; i++) begin
            clr();
            bus.alloc_req = 1;
            bus.alloc_rs1_rdy = (i < 2);
            bus.alloc_rs1_tag = 4'd3;
            bus.alloc_rs2_rdy = 1;
            cycle();
        end
        rdy = 0;
        clr();
        bus.alu_cdb_en = 1;
        bus.alu_cdb_tag = 4'd3;
        bus.alloc_req = 1;
        bus.issue_ready = 1;
        repeat (4) cycle();
        rdy = 1;
        clr();
        bus.issue_ready = 1;
        repeat (4) cycle();
        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 59) == 0);
            bus.alloc_req = ($urandom_range(0, 3) != 0);
            bus.alloc_rs1_rdy = 1'($urandom_range(0, 1));
            bus.alloc_rs1_tag = 4'($urandom_range(0, 7));
            bus.alloc_rs2_rdy = 1'($urandom_range(0, 1));
            bus.alloc_rs2_tag = 4'($urandom_range(0, 7));
            bus.alu_cdb_en = 1'($urandom_range(0, 1));
            bus.alu_cdb_tag = 4'($urandom_range(0, 7));
            bus.lsb_cdb_en = 1'($urandom_range(0, 1));
            bus.lsb_cdb_tag = 4'($urandom_range(0, 7));
            bus.issue_ready = ($urandom_range(0, 2) == 0);
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
